// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier arbiter slice: FSM state encoding and
// the helper that sizes client ID fields.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // A single-client build still needs a one-bit ID field.
  function automatic int id_width(input int clients);
    return (clients > 1) ? $clog2(clients) : 1;
  endfunction

endpackage

// File: rtl/multiplier_arbiter_if.sv
// Client request/response bus of the multiplier arbiter; master is the client
// side, slave is the arbiter side.
interface multiplier_arbiter_if #(
  parameter int BITS       = 8,
  parameter int REQUESTERS = 4
);
  import multiplier_pkg::*;

  localparam int ID_BITS = id_width(REQUESTERS);

  logic [REQUESTERS-1:0]      i_req_valid;
  logic [REQUESTERS-1:0]      o_req_ready;
  logic [REQUESTERS*BITS-1:0] i_req_multiplicand;
  logic [REQUESTERS*BITS-1:0] i_req_multiplier;
  logic                       o_resp_valid;
  logic                       i_resp_ready;
  logic [ID_BITS-1:0]         o_resp_id;
  logic [2*BITS-1:0]          o_resp_product;
  logic                       o_busy;

  modport master (
    output i_req_valid, i_req_multiplicand, i_req_multiplier, i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_id, o_resp_product, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_multiplicand, i_req_multiplier, i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_id, o_resp_product, o_busy
  );

endinterface

// File: rtl/multiplier.sv
// Shift-add unsigned multiplier: BITS cycles per operation, o_finished pulses
// for one cycle in the cycle BITS after the start cycle.
module Multiplier #(
  parameter int BITS = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [BITS-1:0]   i_multiplicand,
  input  logic [BITS-1:0]   i_multiplier,
  output logic [2*BITS-1:0] o_product,
  output logic              o_finished
);

  localparam int CW = $clog2(BITS + 1);

  logic [2*BITS-1:0] mcand;
  logic [BITS-1:0]   mplier;
  logic [CW-1:0]     count;
  logic              running;

  // The start cycle already folds in bit 0, so BITS-1 further steps remain.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_product  <= '0;
      mcand      <= '0;
      mplier     <= '0;
      count      <= '0;
      running    <= 1'b0;
      o_finished <= 1'b0;
    end else if (i_start) begin
      o_product  <= i_multiplier[0] ? {{BITS{1'b0}}, i_multiplicand} : '0;
      mcand      <= {{BITS{1'b0}}, i_multiplicand} << 1;
      mplier     <= i_multiplier >> 1;
      count      <= CW'(BITS - 1);
      running    <= 1'b1;
      o_finished <= 1'b0;
    end else if (running) begin
      if (mplier[0])
        o_product <= o_product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
      if (count == CW'(1)) begin
        running    <= 1'b0;
        o_finished <= 1'b1;
      end
    end else begin
      o_finished <= 1'b0;
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping; the pointer register lives in the parent.
module round_robin_arbiter #(
  parameter int REQUESTERS = 4
) (
  input  logic [REQUESTERS-1:0]                              request,
  input  logic [multiplier_pkg::id_width(REQUESTERS)-1:0]    pointer,
  output logic [REQUESTERS-1:0]                              grant,
  output logic [multiplier_pkg::id_width(REQUESTERS)-1:0]    grant_index,
  output logic                                               any_grant
);
  import multiplier_pkg::*;

  localparam int ID_BITS = id_width(REQUESTERS);

  int idx;

  always_comb begin
    grant       = '0;
    grant_index = '0;
    any_grant   = 1'b0;
    idx         = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      idx = (int'(pointer) + i) % REQUESTERS;
      if (!any_grant && request[idx]) begin
        any_grant        = 1'b1;
        grant[idx]       = 1'b1;
        grant_index      = ID_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one Multiplier among REQUESTERS clients with round-robin arbitration
// and a single ID-tagged response channel.
module multiplier_arbiter #(
  parameter int BITS       = 8,
  parameter int REQUESTERS = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  multiplier_arbiter_if.slave  bus
);
  import multiplier_pkg::*;

  localparam int ID_BITS = id_width(REQUESTERS);

  state_t              state;
  logic [ID_BITS-1:0]  rr_ptr;
  logic [ID_BITS-1:0]  cur_id;
  logic [ID_BITS-1:0]  next_ptr;
  logic [ID_BITS-1:0]  arb_ptr;
  logic [ID_BITS-1:0]  grant_index;
  logic [REQUESTERS-1:0] grant;
  logic                any_grant;
  logic                arb_open;
  logic                mult_start;
  logic                mult_finished;
  logic [BITS-1:0]     mult_a;
  logic [BITS-1:0]     mult_b;
  logic [2*BITS-1:0]   mult_product;
  logic                resp_valid;
  logic [2*BITS-1:0]   resp_product;
  logic                busy;

  // In RESP the arbiter must already see the post-handshake priority.
  assign next_ptr = (cur_id == ID_BITS'(REQUESTERS - 1)) ? '0 : cur_id + ID_BITS'(1);
  assign arb_ptr  = (state == RESP) ? next_ptr : rr_ptr;
  assign arb_open = i_reset_n && ((state == IDLE) || (state == RESP && bus.i_resp_ready));
  assign mult_start = arb_open && any_grant;
  assign mult_a = bus.i_req_multiplicand[int'(grant_index)*BITS +: BITS];
  assign mult_b = bus.i_req_multiplier[int'(grant_index)*BITS +: BITS];

  assign bus.o_req_ready    = arb_open ? grant : '0;
  assign bus.o_resp_valid   = resp_valid;
  assign bus.o_resp_id      = cur_id;
  assign bus.o_resp_product = resp_product;
  assign bus.o_busy         = busy;

  round_robin_arbiter #(.REQUESTERS(REQUESTERS)) u_arbiter (
    .request     (bus.i_req_valid),
    .pointer     (arb_ptr),
    .grant       (grant),
    .grant_index (grant_index),
    .any_grant   (any_grant)
  );

  Multiplier #(.BITS(BITS)) u_multiplier (
    .i_clock        (i_clock),
    .i_reset        (~i_reset_n),
    .i_start        (mult_start),
    .i_multiplicand (mult_a),
    .i_multiplier   (mult_b),
    .o_product      (mult_product),
    .o_finished     (mult_finished)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      resp_valid   <= 1'b0;
      resp_product <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_grant) begin
            cur_id <= grant_index;
            busy   <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (mult_finished) begin
            resp_product <= mult_product;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.i_resp_ready) begin
            rr_ptr     <= next_ptr;
            resp_valid <= 1'b0;
            if (any_grant) begin
              cur_id <= grant_index;
              state  <= BUSY;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  start_only_when_free: assert property (@(posedge i_clock) disable iff (!i_reset_n)
    mult_start |-> (state == IDLE || (state == RESP && bus.i_resp_ready)));

  ready_onehot: assert property (@(posedge i_clock) disable iff (!i_reset_n)
    $onehot0(bus.o_req_ready));

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed self-checking bench for multiplier_arbiter with BITS=8, REQUESTERS=4.
module tb_multiplier_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multiplier_arbiter_if #(.BITS(8), .REQUESTERS(4)) bus ();

  multiplier_arbiter #(.BITS(8), .REQUESTERS(4)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int c, input logic [7:0] a, input logic [7:0] b);
    bus.i_req_multiplicand[c*8 +: 8] = a;
    bus.i_req_multiplier[c*8 +: 8]   = b;
    bus.i_req_valid[c]               = 1'b1;
  endtask

  // Called at the negedge of the handshake cycle; returns at the first response cycle.
  task automatic waitResp(input string tag, input logic [3:0] drop, input int exp_id, input int exp_prod);
    int n;
    @(negedge clk);
    bus.i_req_valid  = bus.i_req_valid & ~drop;
    bus.i_resp_ready = 1'b0;
    n = 1;
    while (!bus.o_resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, n, 9);
    checkOutput({tag, "_id"}, 32'(bus.o_resp_id), exp_id);
    checkOutput({tag, "_product"}, 32'(bus.o_resp_product), exp_prod);
    checkOutput({tag, "_busy"}, 32'(bus.o_busy), 1);
  endtask

  task automatic consume(input string tag);
    bus.i_resp_ready = 1'b1;
    @(negedge clk);
    bus.i_resp_ready = 1'b0;
    checkOutput({tag, "_idle"}, {30'd0, bus.o_resp_valid, bus.o_busy}, 0);
  endtask

  task automatic runOne(input string tag, input int c, input logic [7:0] a, input logic [7:0] b, input int prod);
    @(negedge clk);
    applyStimulus(c, a, b);
    #1;
    checkOutput({tag, "_ready"}, 32'(bus.o_req_ready), 32'(1) << c);
    waitResp(tag, 4'(1 << c), c, prod);
    consume(tag);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_prod[4] = '{6, 12, 20, 30};
    int got, cyc, last, n, cnt;

    bus.i_req_valid        = '0;
    bus.i_req_multiplicand = '0;
    bus.i_req_multiplier   = '0;
    bus.i_resp_ready       = 1'b0;

    // Reset state, including ready held low while a client is already valid.
    repeat (3) @(negedge clk);
    bus.i_req_valid = 4'b0100;
    #1;
    checkOutput("rst_ready", 32'(bus.o_req_ready), 0);
    checkOutput("rst_resp_valid", 32'(bus.o_resp_valid), 0);
    checkOutput("rst_resp_id", 32'(bus.o_resp_id), 0);
    checkOutput("rst_resp_product", 32'(bus.o_resp_product), 0);
    checkOutput("rst_busy", 32'(bus.o_busy), 0);
    bus.i_req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single requests and operand boundaries; pointer walks 0 -> 3 -> 1 -> 2 -> 0.
    runOne("single", 2, 8'd13, 8'd11, 143);
    runOne("max", 0, 8'd255, 8'd255, 65025);
    runOne("zero", 1, 8'd0, 8'd200, 0);
    runOne("one", 3, 8'd1, 8'd255, 255);

    // All clients valid, response always accepted: back-to-back service in order.
    @(negedge clk);
    for (int k = 0; k < 4; k++) applyStimulus(k, 8'(k + 2), 8'(k + 3));
    bus.i_resp_ready = 1'b1;
    #1;
    checkOutput("cont_ready", 32'(bus.o_req_ready), 32'b0001);
    got = 0; cyc = 0; last = 0;
    while (got < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.o_resp_valid) begin
        checkOutput("cont_id", 32'(bus.o_resp_id), got % 4);
        checkOutput("cont_product", 32'(bus.o_resp_product), exp_prod[got % 4]);
        checkOutput("cont_spacing", cyc - last, 9);
        last = cyc;
        got++;
      end
    end
    bus.i_req_valid = '0;
    checkOutput("cont_count", got, 5);
    @(negedge clk);
    bus.i_resp_ready = 1'b0;
    checkOutput("cont_drain", {30'd0, bus.o_resp_valid, bus.o_busy}, 0);

    // Backpressure: client 1 served, client 2 arrives while busy and must wait.
    @(negedge clk);
    applyStimulus(1, 8'd7, 8'd9);
    #1;
    checkOutput("bp_ready", 32'(bus.o_req_ready), 32'b0010);
    @(negedge clk);
    bus.i_req_valid[1] = 1'b0;
    applyStimulus(2, 8'd6, 8'd4);
    #1;
    checkOutput("bp_busy_ready", 32'(bus.o_req_ready), 0);
    n = 1;
    while (!bus.o_resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_latency", n, 9);
    repeat (20) begin
      @(negedge clk);
      checkOutput("bp_hold", {9'd0, bus.o_resp_valid, bus.o_resp_id, bus.o_req_ready, bus.o_resp_product},
                  {9'd0, 1'b1, 2'd1, 4'b0000, 16'd63});
    end
    bus.i_resp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(bus.o_req_ready), 32'b0100);
    waitResp("bp_next", 4'b0100, 2, 24);
    consume("bp_next");

    // Reset in cycle 4 of an operation abandons it silently.
    @(negedge clk);
    applyStimulus(0, 8'd9, 8'd9);
    #1;
    checkOutput("rmid_ready", 32'(bus.o_req_ready), 32'b0001);
    @(negedge clk);
    bus.i_req_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_busy", 32'(bus.o_busy), 0);
    checkOutput("rmid_resp_valid", 32'(bus.o_resp_valid), 0);
    checkOutput("rmid_resp_product", 32'(bus.o_resp_product), 0);
    checkOutput("rmid_resp_id", 32'(bus.o_resp_id), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.o_resp_valid || bus.o_busy) cnt++;
    end
    checkOutput("rmid_no_resp", cnt, 0);
    runOne("post_rst", 1, 8'd3, 8'd5, 15);

    // Sparse fairness with pointer at 2: client 3 first, then client 1 in the handshake cycle.
    @(negedge clk);
    applyStimulus(1, 8'd10, 8'd10);
    applyStimulus(3, 8'd12, 8'd12);
    #1;
    checkOutput("sparse_ready", 32'(bus.o_req_ready), 32'b1000);
    waitResp("sparse3", 4'b1000, 3, 144);
    bus.i_resp_ready = 1'b1;
    #1;
    checkOutput("sparse_handoff", 32'(bus.o_req_ready), 32'b0010);
    waitResp("sparse1", 4'b0010, 1, 100);
    consume("sparse1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
